// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port between instruction fetch (I) and load/store (D).
// Zero-cycle forwarding from IDLE, at most one outstanding transaction, and a watchdog on BUSY.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  // port I (instruction fetch)
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_wMask,
  input  logic [63:0] i_wData,
  output logic [63:0] i_rData,
  output logic        i_hit,
  output logic        i_rvalid,
  // port D (load/store)
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_wMask,
  input  logic [63:0] d_wData,
  output logic [63:0] d_rData,
  output logic        d_hit,
  output logic        d_rvalid,
  // downstream memory port
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wMask,
  output logic [63:0] mem_wData,
  input  logic [63:0] mem_rData,
  input  logic        mem_hit,
  input  logic        mem_rvalid,
  output logic        err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic       PORT_I = 1'b0;
  localparam logic       PORT_D = 1'b1;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic        r_owner;
  logic        r_last;
  logic [7:0]  r_wdog;
  logic        r_err;

  logic        r_i_pv;
  logic        r_i_pren;
  logic        r_i_pwen;
  logic [31:0] r_i_paddr;
  logic [7:0]  r_i_pmask;
  logic [63:0] r_i_pdata;

  logic        r_d_pv;
  logic        r_d_pren;
  logic        r_d_pwen;
  logic [31:0] r_d_paddr;
  logic [7:0]  r_d_pmask;
  logic [63:0] r_d_pdata;

  logic        w_idle;
  logic        w_busy;

  logic        w_i_req;
  logic        w_i_bad;
  logic        w_i_live;
  logic        w_i_cand;
  logic        w_i_cap;
  logic        w_i_c_ren;
  logic        w_i_c_wen;
  logic [31:0] w_i_c_addr;
  logic [7:0]  w_i_c_mask;
  logic [63:0] w_i_c_data;

  logic        w_d_req;
  logic        w_d_bad;
  logic        w_d_live;
  logic        w_d_cand;
  logic        w_d_cap;
  logic        w_d_c_ren;
  logic        w_d_c_wen;
  logic [31:0] w_d_c_addr;
  logic [7:0]  w_d_c_mask;
  logic [63:0] w_d_c_data;

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_grant;
  logic        w_gport;
  logic        w_grant_hit;
  logic        w_done_ok;
  logic        w_timeout;
  logic        w_resp_port;
  logic        w_resp_rvalid;
  logic [63:0] w_resp_data;

  assign w_idle = (r_state == S_IDLE) && !reset;
  assign w_busy = (r_state == S_BUSY) && !reset;

  // A live pulse is legal only with exactly one of ren/wen and an empty slot.
  assign w_i_req  = i_ren | i_wen;
  assign w_i_bad  = (i_ren & i_wen) | (w_i_req & r_i_pv);
  assign w_i_live = w_i_req & ~w_i_bad;
  assign w_i_cand = r_i_pv | w_i_live;

  assign w_d_req  = d_ren | d_wen;
  assign w_d_bad  = (d_ren & d_wen) | (w_d_req & r_d_pv);
  assign w_d_live = w_d_req & ~w_d_bad;
  assign w_d_cand = r_d_pv | w_d_live;

  assign w_i_c_ren  = r_i_pv ? r_i_pren  : i_ren;
  assign w_i_c_wen  = r_i_pv ? r_i_pwen  : i_wen;
  assign w_i_c_addr = r_i_pv ? r_i_paddr : i_addr;
  assign w_i_c_mask = r_i_pv ? r_i_pmask : i_wMask;
  assign w_i_c_data = r_i_pv ? r_i_pdata : i_wData;

  assign w_d_c_ren  = r_d_pv ? r_d_pren  : d_ren;
  assign w_d_c_wen  = r_d_pv ? r_d_pwen  : d_wen;
  assign w_d_c_addr = r_d_pv ? r_d_paddr : d_addr;
  assign w_d_c_mask = r_d_pv ? r_d_pmask : d_wMask;
  assign w_d_c_data = r_d_pv ? r_d_pdata : d_wData;

  assign w_grant_i   = w_idle & w_i_cand & (~w_d_cand | (r_last == PORT_D));
  assign w_grant_d   = w_idle & w_d_cand & (~w_i_cand | (r_last == PORT_I));
  assign w_grant     = w_grant_i | w_grant_d;
  assign w_gport     = w_grant_d ? PORT_D : PORT_I;
  assign w_grant_hit = w_grant & mem_hit;

  assign w_i_cap = w_i_live & ~w_grant_i & !reset;
  assign w_d_cap = w_d_live & ~w_grant_d & !reset;

  // The abort fires in the BUSY cycle where the counter would reach TIMEOUT.
  assign w_done_ok = w_busy & mem_rvalid;
  assign w_timeout = w_busy & ~mem_rvalid & (r_wdog == WD_LAST);

  assign w_resp_port   = w_grant ? w_gport : r_owner;
  assign w_resp_rvalid = w_done_ok | w_timeout;
  assign w_resp_data   = (w_grant_hit | w_done_ok) ? mem_rData : 64'd0;

  always_comb begin
    // NOTE: every output is given a default first so no path can infer a latch.
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wMask = '0;
    mem_wData = '0;
    i_rData   = '0;
    i_hit     = 1'b0;
    i_rvalid  = 1'b0;
    d_rData   = '0;
    d_hit     = 1'b0;
    d_rvalid  = 1'b0;
    if (w_grant) begin
      mem_ren   = w_grant_d ? w_d_c_ren  : w_i_c_ren;
      mem_wen   = w_grant_d ? w_d_c_wen  : w_i_c_wen;
      mem_addr  = w_grant_d ? w_d_c_addr : w_i_c_addr;
      mem_wMask = w_grant_d ? w_d_c_mask : w_i_c_mask;
      mem_wData = w_grant_d ? w_d_c_data : w_i_c_data;
    end
    if (w_resp_port == PORT_I) begin
      i_rData  = w_resp_data;
      i_hit    = w_grant_hit;
      i_rvalid = w_resp_rvalid;
    end else begin
      d_rData  = w_resp_data;
      d_hit    = w_grant_hit;
      d_rvalid = w_resp_rvalid;
    end
  end

  assign err = r_err;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= PORT_I;
      r_last  <= PORT_D;
      r_wdog  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last <= w_gport;
            if (!mem_hit) begin
              r_state <= S_BUSY;
              r_owner <= w_gport;
              r_wdog  <= 8'd0;
            end
          end
        end
        S_BUSY: begin
          if (w_done_ok || w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_timeout || w_i_bad || w_d_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_pv <= 1'b0;
      r_d_pv <= 1'b0;
    end else begin
      if (w_grant_i && r_i_pv) begin
        r_i_pv <= 1'b0;
      end else if (w_i_cap) begin
        r_i_pv <= 1'b1;
      end
      if (w_grant_d && r_d_pv) begin
        r_d_pv <= 1'b0;
      end else if (w_d_cap) begin
        r_d_pv <= 1'b1;
      end
    end
  end

  // NOTE: slot payloads carry no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clock) begin
    if (w_i_cap) begin
      r_i_pren  <= i_ren;
      r_i_pwen  <= i_wen;
      r_i_paddr <= i_addr;
      r_i_pmask <= i_wMask;
      r_i_pdata <= i_wData;
    end
    if (w_d_cap) begin
      r_d_pren  <= d_ren;
      r_d_pwen  <= d_wen;
      r_d_paddr <= d_addr;
      r_d_pmask <= d_wMask;
      r_d_pdata <= d_wData;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with the default watchdog and a TIMEOUT=4 copy.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later, mid-cycle.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_ren, i_wen, d_ren, d_wen;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_wMask, d_wMask;
  logic [63:0] i_wData, d_wData;
  logic [63:0] mem_rData;
  logic        mem_hit, mem_rvalid;

  logic [63:0] i_rData, d_rData;
  logic        i_hit, i_rvalid, d_hit, d_rvalid;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wMask;
  logic [63:0] mem_wData;
  logic        err;

  logic [63:0] w4_i_rData, w4_d_rData;
  logic        w4_i_hit, w4_i_rvalid, w4_d_hit, w4_d_rvalid;
  logic        w4_mem_ren, w4_mem_wen;
  logic [31:0] w4_mem_addr;
  logic [7:0]  w4_mem_wMask;
  logic [63:0] w4_mem_wData;
  logic        w4_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wMask(i_wMask), .i_wData(i_wData),
    .i_rData(i_rData), .i_hit(i_hit), .i_rvalid(i_rvalid),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wMask(d_wMask), .d_wData(d_wData),
    .d_rData(d_rData), .d_hit(d_hit), .d_rvalid(d_rvalid),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wMask(mem_wMask),
    .mem_wData(mem_wData), .mem_rData(mem_rData), .mem_hit(mem_hit), .mem_rvalid(mem_rvalid),
    .err(err)
  );

  mem_arbiter #(.TIMEOUT(4)) dut4 (
    .clock(clock), .reset(reset),
    .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wMask(i_wMask), .i_wData(i_wData),
    .i_rData(w4_i_rData), .i_hit(w4_i_hit), .i_rvalid(w4_i_rvalid),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wMask(d_wMask), .d_wData(d_wData),
    .d_rData(w4_d_rData), .d_hit(w4_d_hit), .d_rvalid(w4_d_rvalid),
    .mem_ren(w4_mem_ren), .mem_wen(w4_mem_wen), .mem_addr(w4_mem_addr), .mem_wMask(w4_mem_wMask),
    .mem_wData(w4_mem_wData), .mem_rData(mem_rData), .mem_hit(mem_hit), .mem_rvalid(mem_rvalid),
    .err(w4_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    i_ren = 1'b0; i_wen = 1'b0; i_addr = '0; i_wMask = '0; i_wData = '0;
    d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wMask = '0; d_wData = '0;
    mem_rData = '0; mem_hit = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got expired, expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int busy_cycles;
    int d_pulses;
    int i_pulses;

    do_reset();
    #1;
    check("rst_mem_ren",   64'(mem_ren),   64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_i_rvalid",  64'(i_rvalid),  64'd0);
    check("rst_d_hit",     64'(d_hit),     64'd0);
    check("rst_err",       64'(err),       64'd0);

    // Single I read hitting in the grant cycle.
    next_cycle(); clr();
    i_ren = 1'b1; i_addr = 32'h8000_0004;
    mem_hit = 1'b1; mem_rData = 64'h1122_3344_5566_7788;
    #1;
    check("t1_mem_ren",  64'(mem_ren),  64'd1);
    check("t1_mem_wen",  64'(mem_wen),  64'd0);
    check("t1_mem_addr", 64'(mem_addr), 64'h8000_0004);
    check("t1_i_hit",    64'(i_hit),    64'd1);
    check("t1_i_rData",  i_rData,       64'h1122_3344_5566_7788);
    check("t1_d_hit",    64'(d_hit),    64'd0);
    check("t1_d_rData",  d_rData,       64'd0);
    next_cycle(); clr(); #1;
    check("t1_after_mem_ren", 64'(mem_ren), 64'd0);
    check("t1_after_i_hit",   64'(i_hit),   64'd0);

    // D write miss, rvalid five cycles after the grant.
    next_cycle(); clr();
    d_wen = 1'b1; d_addr = 32'h0000_1000; d_wMask = 8'h0F; d_wData = 64'hA5A5_0000_1234_5678;
    #1;
    check("t2_mem_wen",   64'(mem_wen),   64'd1);
    check("t2_mem_ren",   64'(mem_ren),   64'd0);
    check("t2_mem_addr",  64'(mem_addr),  64'h1000);
    check("t2_mem_wMask", 64'(mem_wMask), 64'h0F);
    check("t2_mem_wData", mem_wData,      64'hA5A5_0000_1234_5678);
    check("t2_d_hit",     64'(d_hit),     64'd0);
    busy_cycles = 0; d_pulses = 0; i_pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle(); clr();
      if (c == 5) begin
        mem_rvalid = 1'b1; mem_rData = 64'h55;
      end
      #1;
      if (dut.r_state == 1'b1) busy_cycles++;
      if (d_rvalid) d_pulses++;
      if (i_rvalid) i_pulses++;
      if (c == 5) check("t2_d_rvalid_at_5", 64'(d_rvalid), 64'd1);
    end
    check("t2_busy_cycles", 64'(busy_cycles), 64'd5);
    check("t2_d_pulses",    64'(d_pulses),    64'd1);
    check("t2_i_pulses",    64'(i_pulses),    64'd0);

    // Conflict straight after reset: I wins, D issued the cycle after I's rvalid.
    do_reset();
    i_ren = 1'b1; i_addr = 32'h100;
    d_ren = 1'b1; d_addr = 32'h200;
    #1;
    check("t3_grant1_ren",  64'(mem_ren),  64'd1);
    check("t3_grant1_addr", 64'(mem_addr), 64'h100);
    next_cycle(); clr(); #1;
    check("t3_wait_ren", 64'(mem_ren), 64'd0);
    next_cycle(); clr();
    mem_rvalid = 1'b1; mem_rData = 64'hCAFE_0001;
    #1;
    check("t3_i_rvalid", 64'(i_rvalid), 64'd1);
    check("t3_i_rData",  i_rData,       64'hCAFE_0001);
    check("t3_d_rvalid", 64'(d_rvalid), 64'd0);
    check("t3_d_rData",  d_rData,       64'd0);
    check("t3_rv_ren",   64'(mem_ren),  64'd0);
    next_cycle(); clr(); #1;
    check("t3_grant2_ren",  64'(mem_ren),  64'd1);
    check("t3_grant2_addr", 64'(mem_addr), 64'h200);
    next_cycle(); clr();
    mem_rvalid = 1'b1; mem_rData = 64'hCAFE_0002;
    #1;
    check("t3_d_rvalid2", 64'(d_rvalid), 64'd1);
    check("t3_i_rvalid2", 64'(i_rvalid), 64'd0);
    // A lone I hit makes I the most recent grant, so the next conflict goes to D.
    next_cycle(); clr();
    i_ren = 1'b1; i_addr = 32'h140; mem_hit = 1'b1;
    #1;
    check("t3_lone_i_hit", 64'(i_hit), 64'd1);
    next_cycle(); clr();
    i_ren = 1'b1; i_addr = 32'h300;
    d_ren = 1'b1; d_addr = 32'h400;
    #1;
    check("t3_grant3_addr", 64'(mem_addr), 64'h400);
    next_cycle(); clr();
    mem_rvalid = 1'b1;
    #1;
    check("t3_d_rvalid3", 64'(d_rvalid), 64'd1);
    check("t3_i_rvalid3", 64'(i_rvalid), 64'd0);
    next_cycle(); clr();
    mem_hit = 1'b1;
    #1;
    check("t3_grant4_ren",  64'(mem_ren),  64'd1);
    check("t3_grant4_addr", 64'(mem_addr), 64'h300);
    check("t3_i_hit4",      64'(i_hit),    64'd1);

    // I request arriving while D is BUSY waits for D's rvalid.
    next_cycle(); clr();
    d_ren = 1'b1; d_addr = 32'h600;
    #1;
    check("t4_d_grant_addr", 64'(mem_addr), 64'h600);
    next_cycle(); clr();
    i_ren = 1'b1; i_addr = 32'h500;
    #1;
    check("t4_busy_ren_a", 64'(mem_ren), 64'd0);
    next_cycle(); clr(); #1;
    check("t4_busy_ren_b", 64'(mem_ren), 64'd0);
    next_cycle(); clr();
    mem_rvalid = 1'b1;
    #1;
    check("t4_d_rvalid",  64'(d_rvalid), 64'd1);
    check("t4_i_rvalid",  64'(i_rvalid), 64'd0);
    check("t4_rv_ren",    64'(mem_ren),  64'd0);
    next_cycle(); clr();
    mem_hit = 1'b1;
    #1;
    check("t4_i_grant_ren",  64'(mem_ren),  64'd1);
    check("t4_i_grant_addr", 64'(mem_addr), 64'h500);
    check("t4_i_hit",        64'(i_hit),    64'd1);

    // ren and wen together is a violation: dropped and flagged.
    next_cycle(); clr();
    i_ren = 1'b1; i_wen = 1'b1; i_addr = 32'h50;
    #1;
    check("t5_viol_ren", 64'(mem_ren), 64'd0);
    check("t5_viol_wen", 64'(mem_wen), 64'd0);
    next_cycle(); clr(); #1;
    check("t5_err",         64'(err),     64'd1);
    check("t5_not_pending", 64'(mem_ren), 64'd0);

    // Watchdog on the TIMEOUT=4 instance.
    do_reset();
    i_ren = 1'b1; i_addr = 32'h700;
    #1;
    check("t6_grant", 64'(w4_mem_ren), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); clr(); #1;
      check($sformatf("t6_no_rvalid_%0d", c), 64'(w4_i_rvalid), 64'd0);
    end
    check("t6_err_early", 64'(w4_err), 64'd0);
    next_cycle(); clr();
    mem_rData = 64'hDEAD;
    #1;
    check("t6_abort_rvalid", 64'(w4_i_rvalid), 64'd1);
    check("t6_abort_rData",  w4_i_rData,       64'd0);
    check("t6_abort_d",      64'(w4_d_rvalid), 64'd0);
    next_cycle(); clr(); #1;
    check("t6_err",        64'(w4_err),      64'd1);
    check("t6_one_pulse",  64'(w4_i_rvalid), 64'd0);
    next_cycle(); clr();
    mem_rvalid = 1'b1; mem_rData = 64'hBEEF;
    #1;
    check("t6_late_i_rvalid", 64'(w4_i_rvalid), 64'd0);
    check("t6_late_i_rData",  w4_i_rData,       64'd0);
    check("t6_late_d_rvalid", 64'(w4_d_rvalid), 64'd0);

    // Reset during BUSY with D pending and err set.
    do_reset();
    i_ren = 1'b1; i_addr = 32'h800;
    next_cycle(); clr();
    d_ren = 1'b1; d_addr = 32'h900;
    next_cycle(); clr();
    d_ren = 1'b1; d_addr = 32'h901;
    next_cycle(); clr(); #1;
    check("t7_err_before", 64'(err), 64'd1);
    reset = 1'b1;
    next_cycle(); clr();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rData = 64'h77;
    #1;
    check("t7_mem_ren",  64'(mem_ren),  64'd0);
    check("t7_mem_wen",  64'(mem_wen),  64'd0);
    check("t7_mem_addr", 64'(mem_addr), 64'd0);
    check("t7_i_rvalid", 64'(i_rvalid), 64'd0);
    check("t7_i_rData",  i_rData,       64'd0);
    check("t7_d_rvalid", 64'(d_rvalid), 64'd0);
    check("t7_d_hit",    64'(d_hit),    64'd0);
    check("t7_err",      64'(err),      64'd0);
    next_cycle(); clr();
    d_ren = 1'b1; d_addr = 32'hA00; mem_hit = 1'b1; mem_rData = 64'h99;
    #1;
    check("t7_new_ren",  64'(mem_ren),  64'd1);
    check("t7_new_addr", 64'(mem_addr), 64'hA00);
    check("t7_new_hit",  64'(d_hit),    64'd1);
    check("t7_new_data", d_rData,       64'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 64-bit memory port between the instruction fetch unit (port I) and the load/store unit (port D). It sits between the core's fetch and memory stages and the memory/cache model. It keeps the same request/response protocol on both sides: a one-cycle `ren`/`wen` pulse, then either a same-cycle `hit` or a later `rvalid` pulse. At most one downstream transaction is outstanding. Conflicts are resolved round-robin, and a watchdog bounds stalled transactions.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY before the watchdog aborts the transaction (8-bit counter, 1..255).
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `i_ren`, `i_wen` input 1: port I read/write request pulses.
- `i_addr` input 32: port I address.
- `i_wMask` input 8: port I write byte mask.
- `i_wData` input 64: port I write data.
- `i_rData` output 64: port I read data.
- `i_hit` output 1: port I same-cycle completion.
- `i_rvalid` output 1: port I deferred completion.
- `d_*`: identical set of signals for port D.
- `mem_ren`, `mem_wen` output 1: downstream request pulses.
- `mem_addr` output 32, `mem_wMask` output 8, `mem_wData` output 64: downstream request fields.
- `mem_rData` input 64, `mem_hit` input 1, `mem_rvalid` input 1: downstream response.
- `err` output 1: sticky error flag. Set by a watchdog abort or a protocol violation.

## Operation
- States: IDLE and BUSY. Registers:
  - `owner`: port that owns the current transaction.
  - `last`: port granted most recently. Reset value is D, so I wins the first conflict.
  - One pending slot per port: valid bit plus ren, wen, addr, wMask, wData.
  - Watchdog counter.
- Candidate for a port: its pending slot if valid, otherwise its live `ren|wen` pulse. A live pulse is captured into the pending slot whenever it is not granted in that same cycle.
- IDLE:
  - One candidate: grant it.
  - Two candidates: grant the port that is not `last`.
  - On a grant:
    - Drive `mem_*` combinationally from the granted candidate for exactly one cycle.
    - Set `last` to the granted port.
    - Clear that port's pending slot.
  - If `mem_hit` is asserted in the grant cycle:
    - Route `mem_rData` to the owner's `rData` and pulse the owner's `hit` in the same cycle.
    - Stay in IDLE.
  - Otherwise go to BUSY with `owner` set to the granted port.
- BUSY:
  - `mem_ren` and `mem_wen` are held at 0.
  - New live requests go to the pending slots.
  - When `mem_rvalid` arrives: pulse the owner's `rvalid` with `mem_rData` in the same cycle, then return to IDLE.
- Response routing:
  - The non-owner port always sees `hit=0` and `rvalid=0`.
  - `rData` to the non-owner port is 0.
  - `mem_hit` and `mem_rvalid` are ignored when no transaction is being issued or outstanding.
- Write requests use the same completion rules. `rData` is don't-care on write completion.
- Protocol violation: a live request on a port whose pending slot is already valid, or `ren` and `wen` high together. On a violation, set `err`, drop the new request, and keep the existing slot.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching `TIMEOUT` without `mem_rvalid`: pulse the owner's `rvalid` with `rData`=0, set `err`, return to IDLE.
  - A late `mem_rvalid` that arrives afterwards is ignored.

## Timing
- Reset values:
  - State IDLE, `last`=D, pending slots empty, counter 0, `err`=0.
  - All `mem_*` request outputs 0.
  - All `i_*`/`d_*` response outputs 0.
- Reset asserted mid-transaction drops the outstanding transaction and any pending requests. No response is delivered.
- Uncontended request while in IDLE: zero-cycle forwarding, so `mem_ren` is high in the same cycle as `i_ren`.
- Hit latency is 0 cycles. Miss latency is the downstream latency: response in the same cycle as `mem_rvalid`.
- Back-to-back: the earliest next grant is the cycle after `rvalid`. With a hit, the next grant can be the following cycle.
- `mem_rvalid` in the same cycle as a new live request: the response is delivered, the request is captured as pending, and it is granted the next cycle.
- The loser of an IDLE conflict is granted, at the earliest, in the cycle after the winner completes.

## Test plan
- Single I read to 0x80000004 with `mem_hit`=1: `mem_ren`=1 and `mem_addr`=0x80000004 in the same cycle; `i_hit`=1 with `i_rData`=`mem_rData` that cycle; `d_hit`=0.
- D write with wMask=0x0F and a miss, `mem_rvalid` 5 cycles later: state BUSY for 5 cycles; `d_rvalid` pulses once in the rvalid cycle; `i_rvalid` stays 0.
- I and D requests in the same cycle after reset, both missing: I is granted first. D is issued in the cycle after I's `rvalid`, with `mem_addr` equal to D's captured address. Repeat the conflict: D wins this time.
- I request arriving while D is BUSY: captured; `mem_ren` stays 0 until D's `rvalid`; I is issued the next cycle with its original address.
- `TIMEOUT`=4 with `mem_rvalid` never asserted: owner `rvalid` pulses after 4 BUSY cycles with `rData`=0, `err`=1; a late `mem_rvalid` produces no port response.
- Reset asserted during BUSY with D pending: all outputs 0 the next cycle, pending slots cleared, `err`=0, and the next request is granted normally.
